// File: rtl/map_writer.sv
// -----------------------------------------------------------------------------
// map_writer
//
// Writable 32x32 one-bit-per-tile playfield map (pellets, doors, other mutable
// tiles). After reset, or when init_start is seen in IDLE, every row is filled
// with FILL, one row per clock. In IDLE, single-tile (SET/CLR/TOGGLE) and
// whole-row (ROWWR) commands are applied, and a running count of set tiles is
// kept. Two combinational read ports use the same row addressing as the static
// maze ROM.
//
// Column x of a row lives in bit (31-x): column 0 is the MSB, i.e. the leftmost
// screen tile.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset_n     asynchronous active-low reset
//   addr_a/b    read row address for port A / B
//   out_a/b     row contents at addr_a / addr_b (combinational, no bypass)
//   cmd_valid   command present
//   cmd_ready   command can be accepted this cycle
//   cmd_op      00 SET, 01 CLR, 10 TOGGLE, 11 ROWWR
//   cmd_row     target row
//   cmd_col     target column (ignored for ROWWR)
//   cmd_data    new row value (ROWWR only)
//   init_start  request a refill with FILL (honoured in IDLE only)
//   busy        high while filling (state INIT); doubles as the state view
//   count       number of set tiles, 0..1024
//   empty       high when count == 0
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready
// are both high; cmd_ready never depends on cmd_valid, and a master holding
// cmd_valid must keep the command stable until that edge.
// -----------------------------------------------------------------------------
module map_writer #(
    parameter logic [31:0] FILL = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_row,
    input  logic [4:0]  cmd_col,
    input  logic [31:0] cmd_data,
    input  logic        init_start,
    output logic        busy,
    output logic [10:0] count,
    output logic        empty
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_CLR    = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_ROWWR  = 2'b11;

    logic [0:0]  state;
    logic [4:0]  r;
    logic [10:0] count_q;
    logic [31:0] mem [32];

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

    logic        accept;
    logic [31:0] old_row;
    logic [31:0] new_row;
    logic [31:0] col_mask;
    logic [5:0]  pop_old;
    logic [5:0]  pop_new;
    logic [5:0]  fill_pop;
    logic [10:0] delta;
    logic        wr_en;
    logic [4:0]  wr_row;
    logic [31:0] wr_data;

    assign cmd_ready = (state == ST_IDLE) && !init_start;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == ST_INIT);
    assign count     = count_q;
    assign empty     = (count_q == 11'd0);
    assign out_a     = mem[addr_a];
    assign out_b     = mem[addr_b];
    assign fill_pop  = popcount32(FILL);

    // Read-modify-write reads the registered row directly; a command in the
    // previous cycle has already been written, so no forwarding is needed.
    assign old_row  = mem[cmd_row];
    assign col_mask = 32'h8000_0000 >> cmd_col;

    always_comb begin
        new_row = old_row;
        case (cmd_op)
            OP_SET:    new_row = old_row | col_mask;
            OP_CLR:    new_row = old_row & ~col_mask;
            OP_TOGGLE: new_row = old_row ^ col_mask;
            OP_ROWWR:  new_row = cmd_data;
            default:   new_row = old_row;
        endcase
    end

    // One delta formula covers every op: for bit ops the popcounts differ by
    // at most one. The 11-bit two's-complement difference wraps correctly
    // when added to count.
    assign pop_old = popcount32(old_row);
    assign pop_new = popcount32(new_row);
    assign delta   = {5'b0, pop_new} - {5'b0, pop_old};

    always_comb begin
        wr_en   = 1'b0;
        wr_row  = cmd_row;
        wr_data = new_row;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_row  = r;
            wr_data = FILL;
        end else if (accept) begin
            wr_en   = 1'b1;
        end
    end

    // Array has no reset; its contents are defined only once INIT completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            r       <= 5'd0;
            count_q <= 11'd0;
        end else if (state == ST_INIT) begin
            // init_start is deliberately ignored here: no restart mid-fill.
            r       <= r + 5'd1;
            count_q <= count_q + {5'b0, fill_pop};
            if (r == 5'd31) begin
                state <= ST_IDLE;
            end
        end else begin
            if (init_start) begin
                state   <= ST_INIT;
                r       <= 5'd0;
                count_q <= 11'd0;
            end else if (accept) begin
                count_q <= count_q + delta;
            end
        end
    end

endmodule
